// File: rtl/vend_pkg.sv
// Shared definitions for the vending datapath: change amount width, coin
// values, hopper request bit positions and the change dispenser state set.
package vend_pkg;

  localparam int unsigned AMT_W = 5;

  localparam logic [AMT_W-1:0] COIN_TEN  = 5'd10;
  localparam logic [AMT_W-1:0] COIN_FIVE = 5'd5;
  localparam logic [AMT_W-1:0] COIN_ONE  = 5'd1;

  // Bit positions inside the one-hot hop_req vector.
  localparam int unsigned HOP_TEN  = 2;
  localparam int unsigned HOP_FIVE = 1;
  localparam int unsigned HOP_ONE  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_REQ,
    ST_WAIT_REL,
    ST_DONE,
    ST_FAULT
  } disp_state_e;

endpackage

// File: rtl/coin_select.sv
// Greedy coin picker: chooses the largest coin that fits in the remaining
// amount and whose hopper still holds stock.
//   remaining  : amount still to pay
//   ten_nz/five_nz/one_nz : hopper holds at least one coin
//   sel        : one-hot hopper selection (HOP_* bit order)
//   value      : value of the selected coin, 0 when nothing fits
//   found      : a coin was selected
module coin_select
  import vend_pkg::*;
(
  input  logic [AMT_W-1:0] remaining,
  input  logic             ten_nz,
  input  logic             five_nz,
  input  logic             one_nz,
  output logic [2:0]       sel,
  output logic [AMT_W-1:0] value,
  output logic             found
);

  always_comb begin
    sel   = '0;
    value = '0;
    found = 1'b0;
    if (ten_nz && (remaining >= COIN_TEN)) begin
      sel[HOP_TEN] = 1'b1;
      value        = COIN_TEN;
      found        = 1'b1;
    end else if (five_nz && (remaining >= COIN_FIVE)) begin
      sel[HOP_FIVE] = 1'b1;
      value         = COIN_FIVE;
      found         = 1'b1;
    end else if (one_nz && (remaining >= COIN_ONE)) begin
      sel[HOP_ONE] = 1'b1;
      value        = COIN_ONE;
      found        = 1'b1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays a change amount as 10/5/1 coins from three hoppers using a greedy
// choice, one coin per req/ack handshake, and tracks hopper inventories.
//   clk, reset      : clock, asynchronous active-low reset
//   change_valid/amt: one-cycle request to pay change_amt (accepted in IDLE)
//   refill          : reload all inventories (IDLE only, change_valid wins)
//   hop_ack         : hopper ejected a coin; held until hop_req drops
//   hop_req         : one-hot eject request {ten, five, one}
//   busy/done       : not idle / one-cycle payout-complete pulse
//   short_amt       : unpaid remainder of the last payout
//   fault           : sticky handshake timeout
//   cnt_ten/five/one: hopper inventories
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned      CNT_W       = 8,
  parameter logic [CNT_W-1:0] TEN_INIT    = 8'd20,
  parameter logic [CNT_W-1:0] FIVE_INIT   = 8'd20,
  parameter logic [CNT_W-1:0] ONE_INIT    = 8'd50,
  parameter int unsigned      ACK_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             change_valid,
  input  logic [AMT_W-1:0] change_amt,
  input  logic             refill,
  input  logic             hop_ack,
  output logic [2:0]       hop_req,
  output logic             busy,
  output logic             done,
  output logic [AMT_W-1:0] short_amt,
  output logic             fault,
  output logic [CNT_W-1:0] cnt_ten,
  output logic [CNT_W-1:0] cnt_five,
  output logic [CNT_W-1:0] cnt_one
);

  localparam int unsigned TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

  disp_state_e      state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [AMT_W-1:0] val_q, val_d;
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       hop_q, hop_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [AMT_W-1:0] short_q, short_d;
  logic [CNT_W-1:0] ten_q, ten_d;
  logic [CNT_W-1:0] five_q, five_d;
  logic [CNT_W-1:0] one_q, one_d;

  logic [2:0]       cs_sel;
  logic [AMT_W-1:0] cs_val;
  logic             cs_found;

  coin_select u_coin_select (
    .remaining (rem_q),
    .ten_nz    (ten_q  != '0),
    .five_nz   (five_q != '0),
    .one_nz    (one_q  != '0),
    .sel       (cs_sel),
    .value     (cs_val),
    .found     (cs_found)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    val_d   = val_q;
    sel_d   = sel_q;
    hop_d   = '0;
    timer_d = timer_q;
    short_d = short_q;
    ten_d   = ten_q;
    five_d  = five_q;
    one_d   = one_q;

    unique case (state_q)
      ST_IDLE: begin
        if (change_valid) begin
          rem_d   = change_amt;
          short_d = '0;
          state_d = ST_SELECT;
        end else if (refill) begin
          ten_d  = TEN_INIT;
          five_d = FIVE_INIT;
          one_d  = ONE_INIT;
        end
      end
      ST_SELECT: begin
        // A zero remainder never finds a coin, so it lands here with short=0.
        if (cs_found) begin
          sel_d   = cs_sel;
          val_d   = cs_val;
          hop_d   = cs_sel;
          timer_d = '0;
          state_d = ST_REQ;
        end else begin
          short_d = rem_q;
          state_d = ST_DONE;
        end
      end
      ST_REQ: begin
        if (hop_ack) begin
          rem_d   = rem_q - val_q;
          timer_d = '0;
          state_d = ST_WAIT_REL;
          if (sel_q[HOP_TEN])  ten_d  = ten_q  - CNT_W'(1);
          if (sel_q[HOP_FIVE]) five_d = five_q - CNT_W'(1);
          if (sel_q[HOP_ONE])  one_d  = one_q  - CNT_W'(1);
        end else if (timer_q == TMR_LAST) begin
          state_d = ST_FAULT;
        end else begin
          hop_d   = sel_q;
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_WAIT_REL: begin
        if (!hop_ack) begin
          state_d = ST_SELECT;
        end else if (timer_q == TMR_LAST) begin
          state_d = ST_FAULT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      val_q   <= '0;
      sel_q   <= '0;
      hop_q   <= '0;
      timer_q <= '0;
      short_q <= '0;
      ten_q   <= TEN_INIT;
      five_q  <= FIVE_INIT;
      one_q   <= ONE_INIT;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      val_q   <= val_d;
      sel_q   <= sel_d;
      hop_q   <= hop_d;
      timer_q <= timer_d;
      short_q <= short_d;
      ten_q   <= ten_d;
      five_q  <= five_d;
      one_q   <= one_d;
    end
  end

  assign hop_req   = hop_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign fault     = (state_q == ST_FAULT);
  assign short_amt = short_q;
  assign cnt_ten   = ten_q;
  assign cnt_five  = five_q;
  assign cnt_one   = one_q;

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;
  import vend_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       change_valid;
  logic [4:0] change_amt;
  logic       refill;
  logic       hop_ack;
  logic [2:0] hop_req;
  logic       busy, done, fault;
  logic [4:0] short_amt;
  logic [7:0] cnt_ten, cnt_five, cnt_one;

  always #5 clk = ~clk;

  change_dispenser #(
    .CNT_W       (8),
    .TEN_INIT    (8'd20),
    .FIVE_INIT   (8'd20),
    .ONE_INIT    (8'd50),
    .ACK_TIMEOUT (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .change_valid (change_valid),
    .change_amt   (change_amt),
    .refill       (refill),
    .hop_ack      (hop_ack),
    .hop_req      (hop_req),
    .busy         (busy),
    .done         (done),
    .short_amt    (short_amt),
    .fault        (fault),
    .cnt_ten      (cnt_ten),
    .cnt_five     (cnt_five),
    .cnt_one      (cnt_one)
  );

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Hopper model: acks ack_delay cycles after a request, records the coin,
  // releases ack once hop_req drops (unless ack_stick holds it high).
  bit          hopper_on = 1'b1;
  bit          ack_stick = 1'b0;
  int unsigned ack_delay = 2;
  int unsigned hcyc = 0;
  int unsigned got_ten, got_five, got_one;
  int unsigned multi_hot = 0;
  int          first_coin = -1;

  initial begin
    hop_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!$onehot0(hop_req)) multi_hot++;
      if (!hopper_on) begin
        hop_ack = 1'b0;
        hcyc    = 0;
      end else if (!hop_ack && hop_req != 3'b000) begin
        if (hcyc >= ack_delay) begin
          hop_ack = 1'b1;
          hcyc    = 0;
          if (hop_req[HOP_TEN])  got_ten++;
          if (hop_req[HOP_FIVE]) got_five++;
          if (hop_req[HOP_ONE])  got_one++;
          if (first_coin < 0) begin
            if (hop_req[HOP_TEN]) first_coin = 2;
            else if (hop_req[HOP_FIVE]) first_coin = 1;
            else first_coin = 0;
          end
        end else begin
          hcyc++;
        end
      end else if (hop_ack && hop_req == 3'b000 && !ack_stick) begin
        hop_ack = 1'b0;
      end
    end
  end

  int unsigned em_ten = 20, em_five = 20, em_one = 50;

  task automatic check_counts(input string tag);
    chk({tag, "_cnt_ten"},  cnt_ten,  em_ten);
    chk({tag, "_cnt_five"}, cnt_five, em_five);
    chk({tag, "_cnt_one"},  cnt_one,  em_one);
  endtask

  task automatic pay(input int unsigned amt, input int unsigned e10, input int unsigned e5,
                     input int unsigned e1, input int unsigned e_short, input bit interfere,
                     input string tag);
    int unsigned c = 0;
    int unsigned t_req = 0;
    int unsigned t_done = 0;
    int unsigned n_done = 0;
    bit          seen_req = 1'b0;
    got_ten = 0; got_five = 0; got_one = 0; first_coin = -1;
    @(negedge clk);
    change_valid = 1'b1;
    change_amt   = amt[4:0];
    @(negedge clk);
    change_valid = 1'b0;
    c = 1;
    while (c < 400) begin
      if (hop_req != 3'b000 && !seen_req) begin seen_req = 1'b1; t_req = c; end
      if (done) begin n_done++; if (n_done == 1) t_done = c; end
      if (n_done > 0 && !done) break;
      if (interfere && c == 6) begin
        change_valid = 1'b1; change_amt = 5'd1; refill = 1'b1;
      end else begin
        change_valid = 1'b0; refill = 1'b0;
      end
      @(negedge clk);
      c++;
    end
    chk({tag, "_done_pulses"}, n_done, 1);
    chk({tag, "_tens"},  got_ten,  e10);
    chk({tag, "_fives"}, got_five, e5);
    chk({tag, "_ones"},  got_one,  e1);
    chk({tag, "_short"}, short_amt, e_short);
    chk({tag, "_busy_after"}, busy, 0);
    if (amt == 0) chk({tag, "_done_latency"}, t_done, 2);
    if (e10 + e5 + e1 > 0) chk({tag, "_req_latency"}, t_req, 2);
    em_ten -= e10; em_five -= e5; em_one -= e1;
    check_counts(tag);
  endtask

  task automatic do_refill(input string tag);
    @(negedge clk); refill = 1'b1;
    @(negedge clk); refill = 1'b0;
    em_ten = 20; em_five = 20; em_one = 50;
    check_counts(tag);
  endtask

  initial begin
    int unsigned n;
    bit          hit;
    reset = 1'b0; change_valid = 1'b0; change_amt = '0; refill = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hop_req", hop_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_short", short_amt, 0);
    chk("rst_fault", fault, 0);
    check_counts("rst");
    reset = 1'b1;

    // 15 = ten then five
    pay(15, 1, 1, 0, 0, 1'b0, "p15");
    chk("p15_first_is_ten", first_coin, 2);
    pay(0, 0, 0, 0, 0, 1'b0, "p0");

    // Empty the five hopper, then 7 must come from ones.
    do_refill("refill1");
    ack_delay = 0;
    for (int i = 0; i < 20; i++) pay(5, 0, 1, 0, 0, 1'b0, "p5");
    chk("five_empty", cnt_five, 0);
    pay(7, 0, 0, 7, 0, 1'b0, "p7");
    chk("p7_cnt_one", cnt_one, 43);

    // Drain tens, then leave three ones for the shortfall case.
    for (int i = 0; i < 20; i++) pay(10, 1, 0, 0, 0, 1'b0, "p10");
    pay(31, 0, 0, 31, 0, 1'b0, "p31");
    pay(9, 0, 0, 9, 0, 1'b0, "p9");
    chk("pre_short_cnt_one", cnt_one, 3);
    pay(10, 0, 0, 3, 7, 1'b0, "short");

    // Busy: second strobe and refill during a payout are ignored.
    do_refill("refill2");
    ack_delay = 2;
    pay(15, 1, 1, 0, 0, 1'b1, "intf");
    chk("intf_cnt_ten_19", cnt_ten, 19);
    do_refill("refill3");

    // Async reset while in WAIT_REL (ack held high).
    ack_stick = 1'b1;
    @(negedge clk); change_valid = 1'b1; change_amt = 5'd5;
    @(negedge clk); change_valid = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (hop_ack && hop_req == 3'b000 && busy) hit = 1'b1;
      else @(negedge clk);
    end
    chk("wrel_reached", hit, 1);
    chk("wrel_five_taken", cnt_five, 19);
    #2 reset = 1'b0;
    #1;
    chk("arst_hop_req", hop_req, 0);
    chk("arst_busy", busy, 0);
    chk("arst_cnt_five", cnt_five, 20);
    hopper_on = 1'b0; ack_stick = 1'b0;
    @(negedge clk); reset = 1'b1;

    // Timeout: no ack at all.
    @(negedge clk); change_valid = 1'b1; change_amt = 5'd5;
    @(negedge clk); change_valid = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      if (hop_req != 3'b000) hit = 1'b1;
      else @(negedge clk);
    end
    chk("to_req_seen", hit, 1);
    n = 0;
    while (!fault && n < 40) begin @(negedge clk); n++; end
    chk("to_cycles", n, 16);
    chk("to_hop_req", hop_req, 0);
    chk("to_busy", busy, 1);
    change_valid = 1'b1; change_amt = 5'd1;
    @(negedge clk); change_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("flt_sticky", fault, 1);
    chk("flt_busy", busy, 1);
    chk("flt_hop_req", hop_req, 0);
    chk("flt_cnt_five", cnt_five, 20);
    #2 reset = 1'b0;
    #1;
    chk("flt_rst_fault", fault, 0);
    chk("flt_rst_busy", busy, 0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("onehot_violations", multi_hot, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
